// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: runs one ROM/RAM/IO bus cycle per request, with region decode,
// active-low selects/strobes, programmable wait states and read-data return.
// Optional build macro: MEM_WAIT_EN adds an active-low mem_wait stall input
// that can stretch ACCESS once the wait counter has expired.
module mem_bus_ctrl #(
  parameter int unsigned           WIDTH          = 16,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter logic [WIDTH-1:0]      ROM_SIZE       = WIDTH'('h8000),
  parameter logic [WIDTH-1:0]      IO_BASE        = WIDTH'('hFF00),
  parameter int unsigned           WAIT_STATES    = 0,
  parameter int unsigned           IO_WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  write,
  input  logic [WIDTH-1:0]      addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_WAIT_EN
  input  logic                  mem_wait,
`endif
  output logic [WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rom_cs,
  output logic                  ram_cs,
  output logic                  io_cs,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_wr_err
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_HOLD    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_ROM = 2'd0,
    REG_RAM = 2'd1,
    REG_IO  = 2'd2
  } region_e;

  state_e                  state_q;
  region_e                 region_q;
  region_e                 region_c;
  logic                    armed_q;
  logic                    wr_n_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0]        addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rom_cs_q;
  logic                    ram_cs_q;
  logic                    io_cs_q;
  logic                    oe_q;
  logic                    we_q;
  logic                    data_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    rom_wr_err_q;
  logic                    mem_ready_c;

  // Device-side ready: stalls only matter once the wait counter is spent.
`ifdef MEM_WAIT_EN
  assign mem_ready_c = mem_wait;
`else
  assign mem_ready_c = 1'b1;
`endif

  // Region decode of the live address bus, used only at acceptance.
  always_comb begin
    region_c = REG_RAM;
    if (addr_in < ROM_SIZE) begin
      region_c = REG_ROM;
    end else if (addr_in >= IO_BASE) begin
      region_c = REG_IO;
    end
  end

  // Bus-cycle sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      region_q     <= REG_RAM;
      armed_q      <= 1'b1;
      wr_n_q       <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rom_cs_q     <= 1'b1;
      ram_cs_q     <= 1'b1;
      io_cs_q      <= 1'b1;
      oe_q         <= 1'b1;
      we_q         <= 1'b1;
      data_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rom_wr_err_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      rom_wr_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            // Accept: latch the bus and assert the select for SETUP.
            armed_q  <= 1'b0;
            addr_q   <= addr_in;
            wdata_q  <= data_in;
            wr_n_q   <= write;
            region_q <= region_c;
            rom_cs_q <= (region_c != REG_ROM);
            ram_cs_q <= (region_c != REG_RAM);
            io_cs_q  <= (region_c != REG_IO);
            oe_q     <= ~write;
            busy_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q   <= (region_q == REG_IO) ? CNT_W'(IO_WAIT_STATES)
                                          : CNT_W'(WAIT_STATES);
          // ROM is never write-strobed.
          we_q    <= wr_n_q | (region_q == REG_ROM);
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (mem_ready_c) begin
            oe_q         <= 1'b1;
            we_q         <= 1'b1;
            done_q       <= 1'b1;
            rom_wr_err_q <= ~wr_n_q & (region_q == REG_ROM);
            if (wr_n_q) begin
              rdata_q <= mem_rdata;
            end
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          rom_cs_q  <= 1'b1;
          ram_cs_q  <= 1'b1;
          io_cs_q   <= 1'b1;
          data_en_q <= wr_n_q;
          state_q   <= S_RELEASE;
        end
        S_RELEASE: begin
          // Wait for req to be released so one request yields one cycle.
          if (req) begin
            data_en_q <= 1'b0;
            armed_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rom_cs     = rom_cs_q;
  assign ram_cs     = ram_cs_q;
  assign io_cs      = io_cs_q;
  assign mem_oe     = oe_q;
  assign mem_we     = we_q;
  assign data_out   = rdata_q;
  assign data_en    = data_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_wr_err = rom_wr_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (default parameters: WAIT_STATES=0,
// IO_WAIT_STATES=2). Build with MEM_WAIT_EN to also exercise the stall input.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        write;
  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  mem_rdata;
`ifdef MEM_WAIT_EN
  logic        mem_wait;
`endif
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        rom_cs, ram_cs, io_cs, mem_oe, mem_we;
  logic [7:0]  data_out;
  logic        data_en, busy, done, rom_wr_err;

  int checks = 0;
  int errors = 0;
  int we_low, rom_low, ram_low, io_low, done_cnt;
  int done_edge;

  mem_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .mem_rdata (mem_rdata),
`ifdef MEM_WAIT_EN
    .mem_wait  (mem_wait),
`endif
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .rom_cs    (rom_cs),
    .ram_cs    (ram_cs),
    .io_cs     (io_cs),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .data_out  (data_out),
    .data_en   (data_en),
    .busy      (busy),
    .done      (done),
    .rom_wr_err(rom_wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and accumulate activity counts.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!mem_we) we_low++;
    if (!rom_cs) rom_low++;
    if (!ram_cs) ram_low++;
    if (!io_cs)  io_low++;
    if (done)    done_cnt++;
  endtask

  task automatic clear_counts();
    we_low = 0; rom_low = 0; ram_low = 0; io_low = 0; done_cnt = 0;
  endtask

  // Request a transaction and run until done; tick 1 is the accepting edge.
  // Bus inputs are scrambled after acceptance to prove they are ignored.
  task automatic run_txn(input logic [15:0] a, input logic [7:0] d,
                         input logic wr_n, input logic [7:0] rd);
    addr_in   = a;
    data_in   = d;
    write     = wr_n;
    mem_rdata = rd;
    req       = 1'b0;
    clear_counts();
    done_edge = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 1) begin
        addr_in = 16'h0001;
        data_in = 8'hFF;
        write   = ~wr_n;
      end
      if (done) begin
        done_edge = i;
        break;
      end
    end
    if (done_edge < 0) check("txn_timeout", 32'd0, 32'd1);
  endtask

  // Release req from RELEASE and confirm return to IDLE.
  task automatic release_req();
    req = 1'b1;
    tick();
    check("rel_busy", busy, 1'b0);
    check("rel_data_en", data_en, 1'b0);
  endtask

  initial begin
    reset = 1'b0; req = 1'b1; write = 1'b1;
    addr_in = '0; data_in = '0; mem_rdata = '0;
`ifdef MEM_WAIT_EN
    mem_wait = 1'b1;
`endif
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_cs", {rom_cs, ram_cs, io_cs}, 3'b111);
    check("rst_strobes", {mem_oe, mem_we}, 2'b11);
    check("rst_pulses", {done, rom_wr_err, data_en}, 3'b000);
    check("rst_regs", {mem_addr, mem_wdata, data_out}, 32'h0);

    // RAM read, no wait states: done on the 3rd edge counting the accept edge.
    run_txn(16'h8123, 8'h00, 1'b1, 8'h5A);
    check("rd_done_edge", done_edge, 3);
    check("rd_ram_low", ram_low, 3);
    check("rd_other_cs", rom_low + io_low, 0);
    check("rd_data_out", data_out, 8'h5A);
    check("rd_addr", mem_addr, 16'h8123);
    check("rd_hold_strobes", {mem_oe, mem_we, ram_cs}, 3'b110);
    // Keep req low 20 cycles: no retrigger, data stays on the bus.
    for (int i = 0; i < 20; i++) tick();
    check("hold_done_cnt", done_cnt, 1);
    check("hold_data_en", data_en, 1'b1);
    check("hold_busy", busy, 1'b1);
    check("hold_cs", ram_cs, 1'b1);
    release_req();

    // Re-assert req: a second transaction runs.
    run_txn(16'h9000, 8'h00, 1'b1, 8'h3C);
    check("rd2_done_edge", done_edge, 3);
    check("rd2_data_out", data_out, 8'h3C);
    tick();
    check("rd2_done_pulse", done, 1'b0);
    release_req();

    // IO write with two wait states.
    run_txn(16'hFF10, 8'hC3, 1'b0, 8'h99);
    check("io_done_edge", done_edge, 5);
    check("io_we_low", we_low, 3);
    check("io_cs_low", io_low, 5);
    check("io_wdata", mem_wdata, 8'hC3);
    check("io_addr", mem_addr, 16'hFF10);
    check("io_keep_rdata", data_out, 8'h3C);
    check("io_no_romerr", rom_wr_err, 1'b0);
    tick();
    check("io_data_en", data_en, 1'b0);
    check("io_cs_rel", io_cs, 1'b1);
    release_req();

    // ROM write: error pulse with done, never a write strobe.
    run_txn(16'h0004, 8'h55, 1'b0, 8'h00);
    check("rom_done_edge", done_edge, 3);
    check("rom_wr_err", rom_wr_err, 1'b1);
    check("rom_we_low", we_low, 0);
    check("rom_cs_low", rom_low, 3);
    tick();
    check("rom_err_pulse", {rom_wr_err, done}, 2'b00);
    release_req();

    // Region boundaries.
    run_txn(16'h7FFF, 8'h00, 1'b1, 8'h11);
    check("b7fff_rom", rom_low, 3);
    check("b7fff_data", data_out, 8'h11);
    tick(); release_req();
    run_txn(16'hFEFF, 8'h00, 1'b1, 8'h22);
    check("bfeff_ram", {ram_low[3:0], done_edge[3:0]}, 8'h33);
    tick(); release_req();
    run_txn(16'hFF00, 8'h00, 1'b1, 8'h44);
    check("bff00_io", {io_low[3:0], done_edge[3:0]}, 8'h55);
    check("bff00_data", data_out, 8'h44);
    tick(); release_req();

    // Reset in the middle of ACCESS of a RAM write.
    addr_in = 16'h8800; data_in = 8'hA7; write = 1'b0; req = 1'b0;
    tick(); tick();
    check("mid_we_access", mem_we, 1'b0);
    req = 1'b1; reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_we", mem_we, 1'b1);
    check("mid_rst_cs", {rom_cs, ram_cs, io_cs}, 3'b111);
    check("mid_rst_busy_done", {busy, done}, 2'b00);
    tick();
    check("mid_rst_idle", busy, 1'b0);

`ifdef MEM_WAIT_EN
    // RAM read stalled 4 cycles by mem_wait; capture on the ready edge.
    addr_in = 16'h8200; write = 1'b1; mem_rdata = 8'h66; mem_wait = 1'b0; req = 1'b0;
    clear_counts();
    done_edge = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 6) begin
        mem_wait  = 1'b1;
        mem_rdata = 8'h77;
      end
      if (done) begin
        done_edge = i;
        break;
      end
    end
    check("mw_done_edge", done_edge, 7);
    check("mw_data_out", data_out, 8'h77);
    check("mw_ram_low", ram_low, 7);
    tick(); release_req();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
